// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin.
// bout is set when the column needs to borrow from the next bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// The result is published on DONE entry and is held until the next operation completes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_borrow;
  logic             r_borrow_out;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_last;

  full_subtractor u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == LAST_BIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_diff       <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_ovf        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Operand MSBs are kept aside because the shift registers consume them.
            r_a      <= a;
            r_b      <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff       <= {w_d, r_res[WIDTH-1:1]};
            r_borrow_out <= w_bout;
            r_ovf        <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == SHIFT);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: an 8-bit and a 3-bit instance compared against an arithmetic reference.
// Covers reset, directed corner values, mid-operation start/reset, back-to-back and random/exhaustive ops.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;
  logic       start3 = 1'b0;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       busy3, done3, borrow3, ovf3;
  logic [2:0] diff3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(borrow3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic ref_model(input int w, input int av, input int bv,
                           output int d, output int bo, output int ov);
    int sa, sb, r;
    d  = (av - bv) & ((1 << w) - 1);
    bo = (av < bv) ? 1 : 0;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r  = sa - sb;
    ov = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int ed, eb, eo, nbusy, cyc;
    logic [7:0] prev;
    logic held;
    ref_model(8, int'(av), int'(bv), ed, eb, eo);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    prev = diff8;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    nbusy = 0; cyc = 0; held = 1'b1;
    while (!done8 && cyc < 40) begin
      if (busy8) nbusy++;
      if (diff8 !== prev) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done_seen"}, 32'(done8), 32'd1);
    check({tag, ".busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, ".held_while_busy"}, 32'(held), 32'd1);
    check({tag, ".diff"}, 32'(diff8), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow8), 32'(eb));
    check({tag, ".ovf"}, 32'(ovf8), 32'(eo));
    $display("op8 %s a=%02h b=%02h diff=%02h borrow=%0d ovf=%0d", tag, av, bv, diff8, borrow8, ovf8);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  task automatic op3(input int av, input int bv);
    int ed, eb, eo, nbusy, cyc;
    ref_model(3, av, bv, ed, eb, eo);
    @(negedge clk);
    a3 = 3'(av); b3 = 3'(bv); start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom);
    nbusy = 0; cyc = 0;
    while (!done3 && cyc < 20) begin
      if (busy3) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check("w3.done_seen", 32'(done3), 32'd1);
    check("w3.busy_cycles", 32'(nbusy), 32'd3);
    check("w3.diff", 32'(diff3), 32'(ed));
    check("w3.borrow", 32'(borrow3), 32'(eb));
    check("w3.ovf", 32'(ovf3), 32'(eo));
    $display("op3 a=%0d b=%0d diff=%0d borrow=%0d ovf=%0d", av, bv, diff3, borrow3, ovf3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, cyc, last_done, nb;
    logic [7:0] ra, rb;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy8), 32'd0);
    check("rst.done", 32'(done8), 32'd0);
    check("rst.diff", 32'(diff8), 32'd0);
    check("rst.borrow", 32'(borrow8), 32'd0);
    check("rst.ovf", 32'(ovf8), 32'd0);
    check("rst.w3_diff", 32'(diff3), 32'd0);
    rst = 1'b0;

    // Directed corner values
    op8(8'h05, 8'h03, "basic");
    op8(8'h00, 8'h01, "wrap");
    op8(8'h80, 8'h01, "ovf_neg");
    op8(8'h7F, 8'hFF, "ovf_pos");
    op8(8'hFF, 8'hFF, "equal");

    // start re-pulsed mid-operation with different operands is ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; nb = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy8) begin
        nb++;
        if (nb == 3) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
        else start8 = 1'b0;
      end else start8 = 1'b0;
      if (done8) begin
        ndone++;
        check("ignore.diff", 32'(diff8), 32'h0F);
        check("ignore.borrow", 32'(borrow8), 32'd0);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("ignore.done_count", 32'(ndone), 32'd1);
    $display("op8 ignore_start a=10 b=01 dones=%0d diff=%02h", ndone, diff8);

    // Reset in the middle of SHIFT aborts without a done pulse
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy8), 32'd0);
    check("abort.done", 32'(done8), 32'd0);
    check("abort.diff", 32'(diff8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) ndone++;
      @(negedge clk);
    end
    check("abort.no_activity", 32'(ndone), 32'd0);
    $display("op8 abort a=33 b=11 activity_after_reset=%0d", ndone);
    op8(8'h33, 8'h11, "after_abort");

    // Back-to-back with start held high
    @(negedge clk);
    a8 = 8'h0A; b8 = 8'h0B; start8 = 1'b1;
    ndone = 0; last_done = -1;
    for (cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        check("b2b.diff", 32'(diff8), 32'hFF);
        check("b2b.borrow", 32'(borrow8), 32'd1);
        if (last_done >= 0) check("b2b.spacing", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        $display("op8 b2b a=0A b=0B done_at=%0d diff=%02h", cyc, diff8);
      end
    end
    start8 = 1'b0;
    check("b2b.done_count", 32'(ndone >= 3), 32'd1);
    repeat (12) @(negedge clk);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, "rand");
    end

    // Exhaustive 3-bit
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        op3(x, y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset; one clock, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: high when unsigned a < b.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of a - b.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 at edge E0 SHALL load a and b into shift registers, clear the borrow flip-flop, clear the bit counter and move to SHIFT.
REQ-014 In SHIFT, edge E0+1+i (i = 0..WIDTH-1) SHALL process bit i, LSB first, through one full-subtractor cell.
REQ-015 At each SHIFT edge, the cell's difference bit SHALL shift into the MSB of the result register, and the cell's borrow SHALL be registered for the next bit.
REQ-016 At edge E0+WIDTH the FSM SHALL enter DONE, and diff, borrow_out (the final borrow) and ovf SHALL be updated at that edge.
REQ-017 ovf SHALL equal (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), computed from the captured operands.
REQ-018 busy SHALL equal 1 only in SHIFT, i.e. for exactly WIDTH cycles per operation.
REQ-019 done SHALL equal 1 only in DONE, for exactly one cycle; DONE SHALL always move to IDLE on the next edge.
REQ-020 Fixed latency: start sampled at E0 -> done high after E0+WIDTH -> IDLE after E0+WIDTH+1.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no effect on the operation in flight.
REQ-022 diff, borrow_out and ovf SHALL hold their last values until the next DONE entry and SHALL NOT change while busy.
REQ-023 a and b SHALL be sampled only at the accepting edge; later input changes SHALL NOT affect the result.
REQ-024 Back-to-back operation: start high in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one operation per WIDTH+2 cycles.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0, borrow flip-flop=0 and counter=0.
REQ-026 Reset SHALL take priority over start; an operation aborted mid-SHIFT SHALL produce no done pulse.
REQ-027 After rst falls, the block SHALL accept start on the first edge.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 The block SHALL instantiate a single combinational sub-module, full_subtractor (inputs x, y, bin; outputs d, bout), as the per-bit cell.
REQ-030 The bit counter SHALL be sized ceil(log2(WIDTH)) + 1 bits.

Verification
REQ-031 With WIDTH=8, a=0x05, b=0x03, start pulse -> done after 8 busy cycles; diff=0x02, borrow_out=0, ovf=0.
REQ-032 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, ovf=0; a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1.
REQ-033 Start a=0x10, b=0x01, then pulse start with a=0xFF, b=0xFF at busy cycle 3 -> single done, diff=0x0F; a and b changed mid-operation do not alter the result.
REQ-034 rst asserted at busy cycle 4 -> next cycle busy=0, done=0, diff=0; no done follows; a fresh start then completes correctly.
REQ-035 Back-to-back: start held high continuously with a=0x0A, b=0x0B -> done every 10 cycles, each with diff=0xFF, borrow_out=1.
REQ-036 With WIDTH=3, all 64 a/b pairs -> diff=(a-b) mod 8, and borrow_out and ovf match a reference model.
